// File: rtl/mm_grader.sv
// Zood/Znarly guess grader: grades a guess against the secret code with a fixed-latency
// sequential pair scan, and tracks rounds, win and game-over for the current game.
module mm_grader #(
  parameter int PEGS       = 4,
  parameter int SYM_W      = 3,
  parameter int MAX_ROUNDS = 8,
  localparam int CW = $clog2(PEGS + 1),
  localparam int RW = $clog2(MAX_ROUNDS + 1)
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  new_game,
  input  logic [PEGS*SYM_W-1:0] master,
  input  logic [PEGS*SYM_W-1:0] guess,
  input  logic                  grade_req,
  output logic                  busy,
  output logic                  result_valid,
  output logic [CW-1:0]         znarly,
  output logic [CW-1:0]         zood,
  output logic [RW-1:0]         round_num,
  output logic                  game_won,
  output logic                  game_over
);

  localparam int IW = $clog2(PEGS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [SYM_W-1:0] g_reg [PEGS];
  logic [SYM_W-1:0] m_reg [PEGS];
  logic [PEGS-1:0]  exact;
  logic [PEGS-1:0]  used;
  logic [PEGS-1:0]  done_peg;
  logic [IW-1:0]    idx_i;
  logic [IW-1:0]    idx_j;
  logic [CW-1:0]    acc;

  logic [PEGS-1:0]  exact_in;
  logic [CW-1:0]    exact_cnt;
  logic             scan_hit;
  logic             last_j;
  logic             last_pair;

  // NOTE: blocking assignments are correct here; each loop iteration builds on the previous
  // partial sum, and every output gets a default first so no latch is inferred.
  always_comb begin
    exact_in  = '0;
    exact_cnt = '0;
    for (int k = 0; k < PEGS; k++) begin
      exact_in[k] = (guess[k*SYM_W +: SYM_W] == master[k*SYM_W +: SYM_W]);
      exact_cnt   = exact_cnt + CW'(exact[k]);
    end
  end

  // A pair matches only if neither peg has already been claimed by an exact or zood match.
  assign scan_hit  = ~done_peg[idx_i] & ~used[idx_j] & (g_reg[idx_i] == m_reg[idx_j]);
  assign last_j    = (idx_j == IW'(PEGS - 1));
  assign last_pair = last_j && (idx_i == IW'(PEGS - 1));

  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_DONE);
  assign game_over    = game_won | (round_num == RW'(MAX_ROUNDS));

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge value of every other register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      exact     <= '0;
      used      <= '0;
      done_peg  <= '0;
      idx_i     <= '0;
      idx_j     <= '0;
      acc       <= '0;
      znarly    <= '0;
      zood      <= '0;
      round_num <= '0;
      game_won  <= '0;
      // NOTE: the code registers are small flop arrays, not RAM, so resetting them is cheap
      // and keeps every internal register at a known zero.
      for (int k = 0; k < PEGS; k++) begin
        g_reg[k] <= '0;
        m_reg[k] <= '0;
      end
    end else if (new_game) begin
      state     <= S_IDLE;
      znarly    <= '0;
      zood      <= '0;
      round_num <= '0;
      game_won  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grade_req && !game_over) state <= S_LOAD;
        end
        S_LOAD: begin
          for (int k = 0; k < PEGS; k++) begin
            g_reg[k] <= guess[k*SYM_W +: SYM_W];
            m_reg[k] <= master[k*SYM_W +: SYM_W];
          end
          exact    <= exact_in;
          used     <= exact_in;
          done_peg <= exact_in;
          acc      <= '0;
          idx_i    <= '0;
          idx_j    <= '0;
          state    <= S_SCAN;
        end
        S_SCAN: begin
          if (scan_hit) begin
            used[idx_j]     <= 1'b1;
            done_peg[idx_i] <= 1'b1;
            acc             <= acc + 1'b1;
          end
          if (last_j) begin
            idx_j <= '0;
            idx_i <= idx_i + 1'b1;
          end else begin
            idx_j <= idx_j + 1'b1;
          end
          if (last_pair) state <= S_DONE;
        end
        S_DONE: begin
          znarly <= exact_cnt;
          zood   <= acc;
          if (round_num != RW'(MAX_ROUNDS)) round_num <= round_num + 1'b1;
          if (exact_cnt == CW'(PEGS)) game_won <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_grader.sv
// Randomised scoreboard bench for mm_grader: a multiset reference model predicts each grade,
// and a negedge monitor pops the prediction when the DUT reports a result.
module tb_mm_grader;

  localparam int PEGS       = 4;
  localparam int SYM_W      = 3;
  localparam int MAX_ROUNDS = 8;
  localparam int CW         = 3;
  localparam int RW         = 4;
  localparam int W          = PEGS * SYM_W;
  localparam int LAT        = PEGS * PEGS + 2;

  logic          CLOCK_50;
  logic          reset;
  logic          new_game;
  logic [W-1:0]  master;
  logic [W-1:0]  guess;
  logic          grade_req;
  logic          busy;
  logic          result_valid;
  logic [CW-1:0] znarly;
  logic [CW-1:0] zood;
  logic [RW-1:0] round_num;
  logic          game_won;
  logic          game_over;

  mm_grader dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .new_game    (new_game),
    .master      (master),
    .guess       (guess),
    .grade_req   (grade_req),
    .busy        (busy),
    .result_valid(result_valid),
    .znarly      (znarly),
    .zood        (zood),
    .round_num   (round_num),
    .game_won    (game_won),
    .game_over   (game_over)
  );

  // Second instance for the six-peg parametrisation.
  logic          new_game6;
  logic [23:0]   master6;
  logic [23:0]   guess6;
  logic          req6;
  logic          busy6;
  logic          rv6;
  logic [2:0]    zn6;
  logic [2:0]    zo6;
  logic [3:0]    rnd6;
  logic          won6;
  logic          over6;

  mm_grader #(.PEGS(6), .SYM_W(4), .MAX_ROUNDS(10)) dut6 (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .new_game    (new_game6),
    .master      (master6),
    .guess       (guess6),
    .grade_req   (req6),
    .busy        (busy6),
    .result_valid(rv6),
    .znarly      (zn6),
    .zood        (zo6),
    .round_num   (rnd6),
    .game_won    (won6),
    .game_over   (over6)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int zn;
    int zo;
    int rnd;
    bit won;
    bit over;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   pend = 1'b0;

  // Game-level model state.
  int m_rounds = 0;
  bit m_won    = 1'b0;

  // Exact hits plus, per symbol, the smaller of the leftover counts in guess and master.
  function automatic void ref_grade(input logic [W-1:0] mc, input logic [W-1:0] gc,
                                    output int zn, output int zo);
    int cg[1 << SYM_W];
    int cm[1 << SYM_W];
    logic [SYM_W-1:0] gs, ms;
    zn = 0;
    zo = 0;
    for (int s = 0; s < (1 << SYM_W); s++) begin
      cg[s] = 0;
      cm[s] = 0;
    end
    for (int k = 0; k < PEGS; k++) begin
      gs = gc[k*SYM_W +: SYM_W];
      ms = mc[k*SYM_W +: SYM_W];
      if (gs == ms) zn++;
      else begin
        cg[gs]++;
        cm[ms]++;
      end
    end
    for (int s = 0; s < (1 << SYM_W); s++) zo += (cg[s] < cm[s]) ? cg[s] : cm[s];
  endfunction

  function automatic logic [W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [W-1:0] r;
    r[0*SYM_W +: SYM_W] = SYM_W'(a);
    r[1*SYM_W +: SYM_W] = SYM_W'(b);
    r[2*SYM_W +: SYM_W] = SYM_W'(c);
    r[3*SYM_W +: SYM_W] = SYM_W'(d);
    return r;
  endfunction

  // Monitor: grab the prediction when result_valid is seen, compare outputs one cycle later.
  always @(negedge CLOCK_50) begin
    if (pend) begin
      check("znarly", znarly, cur.zn);
      check("zood", zood, cur.zo);
      check("round_num", round_num, cur.rnd);
      check("game_won", game_won, cur.won);
      check("game_over", game_over, cur.over);
      pend = 1'b0;
    end
    if (result_valid) begin
      if (q.size() == 0) check("unexpected_result_valid", 1, 0);
      else begin
        cur  = q.pop_front();
        pend = 1'b1;
      end
    end
  end

  // mode: 0 plain, 1 reset mid-scan, 2 new_game mid-scan, 3 extra request while busy.
  task automatic do_grade(input logic [W-1:0] mc, input logic [W-1:0] gc, input int mode);
    bit   acc_ok;
    bit   want_result;
    int   zn, zo, lat;
    exp_t e;
    acc_ok      = !(m_won || m_rounds == MAX_ROUNDS);
    want_result = acc_ok && (mode == 0 || mode == 3);
    ref_grade(mc, gc, zn, zo);
    master    = mc;
    guess     = gc;
    grade_req = 1'b1;
    if (want_result) begin
      e.zn     = zn;
      e.zo     = zo;
      e.rnd    = m_rounds + 1;
      e.won    = m_won | (zn == PEGS);
      e.over   = e.won | (e.rnd == MAX_ROUNDS);
      m_rounds = e.rnd;
      m_won    = e.won;
      q.push_back(e);
    end
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLOCK_50);
      grade_req = 1'b0;
      if (k == 1) check("busy_after_req", busy, acc_ok);
      if (k == 2) begin
        master = W'($urandom);
        guess  = W'($urandom);
      end
      if (mode == 3 && k == 5) grade_req = 1'b1;
      if (mode == 1 && acc_ok && k == 8) begin
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_znarly", znarly, 0);
        check("rst_zood", zood, 0);
        check("rst_round", round_num, 0);
        check("rst_over", game_over, 0);
        m_rounds = 0;
        m_won    = 1'b0;
      end
      if (mode == 1 && k == 9) reset = 1'b0;
      if (mode == 2 && acc_ok && k == 8) new_game = 1'b1;
      if (mode == 2 && acc_ok && k == 9) begin
        new_game = 1'b0;
        check("ng_busy", busy, 0);
        check("ng_round", round_num, 0);
        check("ng_znarly", znarly, 0);
        check("ng_zood", zood, 0);
        m_rounds = 0;
        m_won    = 1'b0;
      end
      if (result_valid && lat < 0) lat = k;
      if (want_result && lat >= 0 && k == lat + 1) break;
    end
    if (want_result) check("result_latency", lat, LAT);
    else check("no_result_valid", lat, -1);
  endtask

  task automatic start_new_game();
    new_game = 1'b1;
    @(negedge CLOCK_50);
    new_game = 1'b0;
    m_rounds = 0;
    m_won    = 1'b0;
    check("newgame_round", round_num, 0);
    check("newgame_over", game_over, 0);
    check("newgame_won", game_won, 0);
    check("newgame_znarly", znarly, 0);
    check("newgame_zood", zood, 0);
  endtask

  initial begin
    logic [W-1:0] mr, gr;
    int lat6;
    reset     = 1'b1;
    new_game  = 1'b0;
    master    = '0;
    guess     = '0;
    grade_req = 1'b0;
    new_game6 = 1'b0;
    master6   = '0;
    guess6    = '0;
    req6      = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("reset_busy", busy, 0);
    check("reset_result_valid", result_valid, 0);
    check("reset_znarly", znarly, 0);
    check("reset_zood", zood, 0);
    check("reset_round", round_num, 0);
    check("reset_won", game_won, 0);
    check("reset_over", game_over, 0);

    // Exact win, then a request that game_over must block.
    do_grade(pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 0);
    do_grade(pack4(1, 2, 3, 4), pack4(4, 3, 2, 1), 0);
    start_new_game();

    do_grade(pack4(1, 1, 2, 2), pack4(2, 2, 1, 1), 0);
    do_grade(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 0);
    do_grade(pack4(5, 5, 0, 0), pack4(0, 5, 5, 7), 0);

    // Fill the remaining rounds with non-winning guesses, then hit the round limit.
    while (m_rounds < MAX_ROUNDS) begin
      mr = W'($urandom);
      gr = W'($urandom);
      if (gr == mr) gr[0] = ~gr[0];
      do_grade(mr, gr, 0);
    end
    check("limit_round", round_num, MAX_ROUNDS);
    check("limit_over", game_over, 1);
    check("limit_won", game_won, 0);
    do_grade(pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 0);
    start_new_game();

    // Busy-drop and abort handling.
    do_grade(pack4(3, 1, 4, 1), pack4(1, 3, 4, 2), 3);
    do_grade(pack4(6, 6, 2, 7), pack4(6, 2, 7, 7), 1);
    do_grade(pack4(0, 1, 2, 3), pack4(0, 1, 3, 2), 0);
    do_grade(pack4(2, 2, 2, 2), pack4(2, 0, 2, 0), 2);

    // Random games over a small alphabet so matches and wins are frequent.
    for (int n = 0; n < 40; n++) begin
      if (m_won || m_rounds == MAX_ROUNDS) start_new_game();
      for (int k = 0; k < PEGS; k++) begin
        mr[k*SYM_W +: SYM_W] = SYM_W'($urandom_range(0, 3));
        gr[k*SYM_W +: SYM_W] = SYM_W'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 5) == 0) gr = mr;
      do_grade(mr, gr, 0);
    end

    // Six-peg instance: reversed code is a full permutation.
    for (int k = 0; k < 6; k++) begin
      master6[k*4 +: 4] = 4'(k);
      guess6[k*4 +: 4]  = 4'(5 - k);
    end
    req6 = 1'b1;
    lat6 = -1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge CLOCK_50);
      req6 = 1'b0;
      if (rv6 && lat6 < 0) lat6 = k;
      if (lat6 >= 0 && k == lat6 + 1) break;
    end
    check("p6_latency", lat6, 38);
    check("p6_znarly", zn6, 0);
    check("p6_zood", zo6, 6);
    check("p6_round", rnd6, 1);

    repeat (2) @(negedge CLOCK_50);
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_grader.md
# mm_grader

Parametrised Zood/Znarly guess grader with a round counter. It replaces the fixed 4-peg, 3-bit, 8-round grader. It sits between the guess-entry logic and the display/game-control logic. It accepts a guess under a request/busy handshake, counts exact matches (Znarly) and multiset colour-only matches (Zood) with a deterministic sequential scan, and tracks rounds, win and game-over.

## Interface

Parameters:
- PEGS, 4: pegs per code, at least 2.
- SYM_W, 3: bits per peg symbol.
- MAX_ROUNDS, 8: rounds before the game is over, at least 1.
- Derived CW = $clog2(PEGS+1). Derived RW = $clog2(MAX_ROUNDS+1).

Ports (reset is asynchronous, active-high; clock is CLOCK_50):
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; forces the reset values listed below.
- new_game  in  1  synchronous clear of the round, win and result state; aborts any grade in flight.
- master  in  PEGS*SYM_W  secret code; peg k is in bits [k*SYM_W +: SYM_W].
- guess  in  PEGS*SYM_W  guess code; same packing as master.
- grade_req  in  1  single-cycle request to grade the current guess against master.
- busy  out  1  high from the cycle after an accepted request through the DONE state.
- result_valid  out  1  one-cycle pulse when znarly and zood are updated.
- znarly  out  CW  count of exact position matches.
- zood  out  CW  count of right-symbol, wrong-position matches; never includes a Znarly peg.
- round_num  out  RW  number of completed grades in this game.
- game_won  out  1  sticky; set when znarly == PEGS.
- game_over  out  1  equals game_won | (round_num == MAX_ROUNDS).

## Operation

States:
- IDLE:
  - grade_req & ~busy & ~game_over accepts the request. Go to LOAD.
  - Otherwise the request is ignored and nothing changes.
- LOAD (1 cycle):
  - Register g[k] and m[k] for all pegs. master and guess may change after this cycle.
  - Compute exact[k] = (g[k] == m[k]).
  - Initialise used[j] = exact[j] and done[i] = exact[i].
  - Clear the zood accumulator, and set i = 0, j = 0.
- SCAN (exactly PEGS*PEGS cycles): each cycle evaluates one (i,j) pair.
  - Match condition: ~done[i] & ~used[j] & (g[i] == m[j]).
  - On a match: set used[j] and done[i], and increment the accumulator.
  - Advance j; when j wraps from PEGS-1 to 0, advance i.
  - Every pair is visited whether or not it matches, so latency is fixed.
- DONE (1 cycle):
  - znarly <= popcount(exact) and zood <= accumulator.
  - Pulse result_valid and increment round_num.
  - Set game_won if popcount(exact) == PEGS.
  - Return to IDLE.

Rules and boundary conditions:
- round_num saturates at MAX_ROUNDS; at that value game_over blocks further requests.
- A winning grade on the last round sets both game_won and game_over.
- znarly, zood, round_num and game_won hold their values between grades.
- grade_req while busy or game_over is dropped, not queued.
- new_game in any state:
  - Next state is IDLE.
  - Clears round_num, game_won, znarly and zood.
  - No result_valid pulse is issued for an aborted grade.
- new_game and grade_req in the same cycle: new_game wins and the request is dropped.
- reset mid-operation: immediately go to IDLE with all reset values.
- Reset values: busy 0, result_valid 0, znarly 0, zood 0, round_num 0, game_won 0, game_over 0. All internal registers are 0.
- Arithmetic: popcount and the accumulator are CW bits wide and cannot overflow, because each count is at most PEGS.

## Timing

- Request accepted in cycle T (IDLE & grade_req). LOAD is T+1, SCAN is T+2 … T+1+PEGS², DONE is T+2+PEGS².
- result_valid is high during DONE. New znarly, zood and round_num are visible from T+3+PEGS².
- For PEGS=4: result_valid at T+18, outputs updated at T+19.
- busy is high from T+1 through DONE; it is low in IDLE.
- The earliest next accepted request is T+3+PEGS².
- game_over is combinational from registered state, with no extra latency.

## Test plan

- Exact win: master 1,2,3,4 and guess 1,2,3,4 (peg0 first) -> znarly 4, zood 0, game_won 1, game_over 1, round_num 1. A following grade_req is ignored.
- Full permutation: master 1,1,2,2 and guess 2,2,1,1 -> znarly 0, zood 4, result_valid exactly at T+18 (PEGS=4).
- Duplicates, no double count: master 1,2,3,4 and guess 1,1,1,1 -> znarly 1, zood 0. Also master 5,5,0,0 and guess 0,5,5,7 -> znarly 1, zood 2.
- Round limit: 8 non-winning grades -> round_num 8, game_over 1, game_won 0. A 9th grade_req produces no busy and no result_valid. new_game -> round_num 0, game_over 0.
- Abort handling:
  - reset asserted during SCAN -> all outputs are 0 immediately and no result_valid follows.
  - new_game during SCAN -> IDLE next cycle, no result_valid pulse.
  - grade_req while busy -> ignored; round_num advances by only 1.
- Parametrisation: PEGS=6, SYM_W=4, MAX_ROUNDS=10 with master 0..5 and guess 5,4,3,2,1,0 -> znarly 0, zood 6, result_valid at T+38.
